// File: rtl/axil_mmio_pkg.sv
// Shared constants and types for the MMIO AXI-Lite demultiplexer.
package axil_mmio_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Write-path state machine
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FWD  = 2'd1,
    W_RESP = 2'd2,
    W_ERR  = 2'd3
  } wstate_e;

  // Read-path state machine
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_FWD  = 2'd1,
    R_RESP = 2'd2,
    R_ERR  = 2'd3
  } rstate_e;

  // Downstream port selected by the address decoder
  typedef enum logic [1:0] {
    SEL_M0   = 2'd0,
    SEL_M1   = 2'd1,
    SEL_MISS = 2'd2
  } sel_e;

endpackage

// File: rtl/axil_mmio_decode.sv
// Combinational address decoder: maps an address to a downstream port or a miss.
module axil_mmio_decode
  import axil_mmio_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] M0_BASE    = 32'h4060_0000,
  parameter logic [ADDR_WIDTH-1:0] M0_MASK    = 32'hFFFF_F000,
  parameter logic [ADDR_WIDTH-1:0] M1_BASE    = 32'h3800_0000,
  parameter logic [ADDR_WIDTH-1:0] M1_MASK    = 32'hFFFF_0000
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output sel_e                  o_sel
);

  // Port 0 wins when both windows match
  always_comb begin
    o_sel = SEL_MISS;
    if ((i_addr & M0_MASK) == M0_BASE) begin
      o_sel = SEL_M0;
    end else if ((i_addr & M1_MASK) == M1_BASE) begin
      o_sel = SEL_M1;
    end
  end

endmodule

// File: rtl/axil_mmio_demux.sv
// AXI4-Lite 1-to-2 demux for MMIO peripherals; unmapped addresses answer DECERR locally.
// Independent read and write paths, one outstanding transaction each, all outputs registered.
module axil_mmio_demux
  import axil_mmio_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] M0_BASE    = 32'h4060_0000,
  parameter logic [ADDR_WIDTH-1:0] M0_MASK    = 32'hFFFF_F000,
  parameter logic [ADDR_WIDTH-1:0] M1_BASE    = 32'h3800_0000,
  parameter logic [ADDR_WIDTH-1:0] M1_MASK    = 32'hFFFF_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  // upstream
  input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic [2:0]              s_axil_awprot,
  input  logic                    s_axil_awvalid,
  output logic                    s_axil_awready,
  input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                    s_axil_wvalid,
  output logic                    s_axil_wready,
  output logic [1:0]              s_axil_bresp,
  output logic                    s_axil_bvalid,
  input  logic                    s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic [2:0]              s_axil_arprot,
  input  logic                    s_axil_arvalid,
  output logic                    s_axil_arready,
  output logic [DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]              s_axil_rresp,
  output logic                    s_axil_rvalid,
  input  logic                    s_axil_rready,
  // port 0
  output logic [ADDR_WIDTH-1:0]   m0_axil_awaddr,
  output logic [2:0]              m0_axil_awprot,
  output logic                    m0_axil_awvalid,
  input  logic                    m0_axil_awready,
  output logic [DATA_WIDTH-1:0]   m0_axil_wdata,
  output logic [DATA_WIDTH/8-1:0] m0_axil_wstrb,
  output logic                    m0_axil_wvalid,
  input  logic                    m0_axil_wready,
  input  logic [1:0]              m0_axil_bresp,
  input  logic                    m0_axil_bvalid,
  output logic                    m0_axil_bready,
  output logic [ADDR_WIDTH-1:0]   m0_axil_araddr,
  output logic [2:0]              m0_axil_arprot,
  output logic                    m0_axil_arvalid,
  input  logic                    m0_axil_arready,
  input  logic [DATA_WIDTH-1:0]   m0_axil_rdata,
  input  logic [1:0]              m0_axil_rresp,
  input  logic                    m0_axil_rvalid,
  output logic                    m0_axil_rready,
  // port 1
  output logic [ADDR_WIDTH-1:0]   m1_axil_awaddr,
  output logic [2:0]              m1_axil_awprot,
  output logic                    m1_axil_awvalid,
  input  logic                    m1_axil_awready,
  output logic [DATA_WIDTH-1:0]   m1_axil_wdata,
  output logic [DATA_WIDTH/8-1:0] m1_axil_wstrb,
  output logic                    m1_axil_wvalid,
  input  logic                    m1_axil_wready,
  input  logic [1:0]              m1_axil_bresp,
  input  logic                    m1_axil_bvalid,
  output logic                    m1_axil_bready,
  output logic [ADDR_WIDTH-1:0]   m1_axil_araddr,
  output logic [2:0]              m1_axil_arprot,
  output logic                    m1_axil_arvalid,
  input  logic                    m1_axil_arready,
  input  logic [DATA_WIDTH-1:0]   m1_axil_rdata,
  input  logic [1:0]              m1_axil_rresp,
  input  logic                    m1_axil_rvalid,
  output logic                    m1_axil_rready
);

  // ---------------- write path ----------------
  wstate_e                 r_wstate;
  sel_e                    r_wsel;
  logic                    r_awready, r_wready, r_aw_held, r_w_held;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [2:0]              r_awprot;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic                    r_m_awvalid, r_m_wvalid, r_m_bready;
  logic                    r_bvalid;
  logic [1:0]              r_bresp;

  logic                    w_aw_hs, w_w_hs;
  logic [ADDR_WIDTH-1:0]   w_aw_addr;
  sel_e                    w_wdec_sel;
  logic                    w_m_awready, w_m_wready, w_m_bvalid;
  logic [1:0]              w_m_bresp;

  assign w_aw_hs   = r_awready && s_axil_awvalid;
  assign w_w_hs    = r_wready && s_axil_wvalid;
  // Decode the address being captured this cycle so the forward starts one cycle later
  assign w_aw_addr = w_aw_hs ? s_axil_awaddr : r_awaddr;

  assign w_m_awready = (r_wsel == SEL_M1) ? m1_axil_awready : m0_axil_awready;
  assign w_m_wready  = (r_wsel == SEL_M1) ? m1_axil_wready  : m0_axil_wready;
  assign w_m_bvalid  = (r_wsel == SEL_M1) ? m1_axil_bvalid  : m0_axil_bvalid;
  assign w_m_bresp   = (r_wsel == SEL_M1) ? m1_axil_bresp   : m0_axil_bresp;

  axil_mmio_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .M0_BASE    (M0_BASE),
    .M0_MASK    (M0_MASK),
    .M1_BASE    (M1_BASE),
    .M1_MASK    (M1_MASK)
  ) u_wdec (
    .i_addr (w_aw_addr),
    .o_sel  (w_wdec_sel)
  );

  // Write FSM: capture AW/W independently, forward or answer DECERR, relay the response
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wstate    <= W_IDLE;
      r_wsel      <= SEL_MISS;
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_aw_held   <= 1'b0;
      r_w_held    <= 1'b0;
      r_awaddr    <= '0;
      r_awprot    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_m_awvalid <= 1'b0;
      r_m_wvalid  <= 1'b0;
      r_m_bready  <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bresp     <= '0;
    end else begin
      unique case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_awaddr  <= s_axil_awaddr;
            r_awprot  <= s_axil_awprot;
            r_aw_held <= 1'b1;
            r_awready <= 1'b0;
          end else if (!r_aw_held) begin
            r_awready <= 1'b1;
          end
          if (w_w_hs) begin
            r_wdata  <= s_axil_wdata;
            r_wstrb  <= s_axil_wstrb;
            r_w_held <= 1'b1;
            r_wready <= 1'b0;
          end else if (!r_w_held) begin
            r_wready <= 1'b1;
          end
          if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_wsel    <= w_wdec_sel;
            if (w_wdec_sel == SEL_MISS) begin
              r_wstate <= W_ERR;
              r_bvalid <= 1'b1;
              r_bresp  <= RESP_DECERR;
            end else begin
              r_wstate    <= W_FWD;
              r_m_awvalid <= 1'b1;
              r_m_wvalid  <= 1'b1;
            end
          end
        end
        W_FWD: begin
          if (r_m_awvalid && w_m_awready) r_m_awvalid <= 1'b0;
          if (r_m_wvalid && w_m_wready) r_m_wvalid <= 1'b0;
          if ((!r_m_awvalid || w_m_awready) && (!r_m_wvalid || w_m_wready)) begin
            r_wstate   <= W_RESP;
            r_m_bready <= 1'b1;
          end
        end
        W_RESP: begin
          if (r_m_bready && w_m_bvalid) begin
            r_m_bready <= 1'b0;
            r_bvalid   <= 1'b1;
            r_bresp    <= w_m_bresp;
          end else if (r_bvalid && s_axil_bready) begin
            r_bvalid  <= 1'b0;
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        W_ERR: begin
          if (s_axil_bready) begin
            r_bvalid  <= 1'b0;
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  rstate_e               r_rstate;
  sel_e                  r_rsel;
  logic                  r_arready;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [2:0]            r_arprot;
  logic                  r_m_arvalid, r_m_rready;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  logic                  w_ar_hs;
  sel_e                  w_rdec_sel;
  logic                  w_m_arready, w_m_rvalid;
  logic [DATA_WIDTH-1:0] w_m_rdata;
  logic [1:0]            w_m_rresp;

  assign w_ar_hs     = r_arready && s_axil_arvalid;
  assign w_m_arready = (r_rsel == SEL_M1) ? m1_axil_arready : m0_axil_arready;
  assign w_m_rvalid  = (r_rsel == SEL_M1) ? m1_axil_rvalid  : m0_axil_rvalid;
  assign w_m_rdata   = (r_rsel == SEL_M1) ? m1_axil_rdata   : m0_axil_rdata;
  assign w_m_rresp   = (r_rsel == SEL_M1) ? m1_axil_rresp   : m0_axil_rresp;

  axil_mmio_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .M0_BASE    (M0_BASE),
    .M0_MASK    (M0_MASK),
    .M1_BASE    (M1_BASE),
    .M1_MASK    (M1_MASK)
  ) u_rdec (
    .i_addr (s_axil_araddr),
    .o_sel  (w_rdec_sel)
  );

  // Read FSM: capture AR, forward or answer DECERR with zero data, relay the response
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rstate    <= R_IDLE;
      r_rsel      <= SEL_MISS;
      r_arready   <= 1'b0;
      r_araddr    <= '0;
      r_arprot    <= '0;
      r_m_arvalid <= 1'b0;
      r_m_rready  <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_rresp     <= '0;
    end else begin
      unique case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_araddr  <= s_axil_araddr;
            r_arprot  <= s_axil_arprot;
            r_arready <= 1'b0;
            r_rsel    <= w_rdec_sel;
            if (w_rdec_sel == SEL_MISS) begin
              r_rstate <= R_ERR;
              r_rvalid <= 1'b1;
              r_rdata  <= '0;
              r_rresp  <= RESP_DECERR;
            end else begin
              r_rstate    <= R_FWD;
              r_m_arvalid <= 1'b1;
            end
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_FWD: begin
          if (w_m_arready) begin
            r_m_arvalid <= 1'b0;
            r_m_rready  <= 1'b1;
            r_rstate    <= R_RESP;
          end
        end
        R_RESP: begin
          if (r_m_rready && w_m_rvalid) begin
            r_m_rready <= 1'b0;
            r_rvalid   <= 1'b1;
            r_rdata    <= w_m_rdata;
            r_rresp    <= w_m_rresp;
          end else if (r_rvalid && s_axil_rready) begin
            r_rvalid  <= 1'b0;
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
          end
        end
        R_ERR: begin
          if (s_axil_rready) begin
            r_rvalid  <= 1'b0;
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // ---------------- outputs (all from registers) ----------------
  assign s_axil_awready = r_awready;
  assign s_axil_wready  = r_wready;
  assign s_axil_bvalid  = r_bvalid;
  assign s_axil_bresp   = r_bresp;
  assign s_axil_arready = r_arready;
  assign s_axil_rvalid  = r_rvalid;
  assign s_axil_rdata   = r_rdata;
  assign s_axil_rresp   = r_rresp;

  assign m0_axil_awaddr  = r_awaddr;
  assign m0_axil_awprot  = r_awprot;
  assign m0_axil_wdata   = r_wdata;
  assign m0_axil_wstrb   = r_wstrb;
  assign m0_axil_araddr  = r_araddr;
  assign m0_axil_arprot  = r_arprot;
  assign m0_axil_awvalid = r_m_awvalid && (r_wsel == SEL_M0);
  assign m0_axil_wvalid  = r_m_wvalid && (r_wsel == SEL_M0);
  assign m0_axil_bready  = r_m_bready && (r_wsel == SEL_M0);
  assign m0_axil_arvalid = r_m_arvalid && (r_rsel == SEL_M0);
  assign m0_axil_rready  = r_m_rready && (r_rsel == SEL_M0);

  assign m1_axil_awaddr  = r_awaddr;
  assign m1_axil_awprot  = r_awprot;
  assign m1_axil_wdata   = r_wdata;
  assign m1_axil_wstrb   = r_wstrb;
  assign m1_axil_araddr  = r_araddr;
  assign m1_axil_arprot  = r_arprot;
  assign m1_axil_awvalid = r_m_awvalid && (r_wsel == SEL_M1);
  assign m1_axil_wvalid  = r_m_wvalid && (r_wsel == SEL_M1);
  assign m1_axil_bready  = r_m_bready && (r_wsel == SEL_M1);
  assign m1_axil_arvalid = r_m_arvalid && (r_rsel == SEL_M1);
  assign m1_axil_rready  = r_m_rready && (r_rsel == SEL_M1);

endmodule

// File: tb/tb_axil_mmio_demux.sv
// Directed bench for axil_mmio_demux: peripherals are driven step by step from one initial block.
module tb_axil_mmio_demux;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
  logic [2:0]  s_awprot = '0, s_arprot = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;

  logic [31:0] m0_awaddr, m0_wdata, m0_araddr, m1_awaddr, m1_wdata, m1_araddr;
  logic [2:0]  m0_awprot, m0_arprot, m1_awprot, m1_arprot;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_awvalid, m0_wvalid, m0_bready, m0_arvalid, m0_rready;
  logic        m1_awvalid, m1_wvalid, m1_bready, m1_arvalid, m1_rready;
  logic        m0_awready = 0, m0_wready = 0, m0_bvalid = 0, m0_arready = 0, m0_rvalid = 0;
  logic        m1_awready = 0, m1_wready = 0, m1_bvalid = 0, m1_arready = 0, m1_rvalid = 0;
  logic [1:0]  m0_bresp = '0, m0_rresp = '0, m1_bresp = '0, m1_rresp = '0;
  logic [31:0] m0_rdata = '0, m1_rdata = '0;

  int checks = 0;
  int errors = 0;

  logic [14:0] all_vr;
  assign all_vr = {s_awready, s_wready, s_arready, s_bvalid, s_rvalid,
                   m0_awvalid, m0_wvalid, m0_arvalid, m0_bready, m0_rready,
                   m1_awvalid, m1_wvalid, m1_arvalid, m1_bready, m1_rready};

  always #5 clk = ~clk;

  axil_mmio_demux dut (
    .clk             (clk),
    .rst             (rst),
    .s_axil_awaddr   (s_awaddr),
    .s_axil_awprot   (s_awprot),
    .s_axil_awvalid  (s_awvalid),
    .s_axil_awready  (s_awready),
    .s_axil_wdata    (s_wdata),
    .s_axil_wstrb    (s_wstrb),
    .s_axil_wvalid   (s_wvalid),
    .s_axil_wready   (s_wready),
    .s_axil_bresp    (s_bresp),
    .s_axil_bvalid   (s_bvalid),
    .s_axil_bready   (s_bready),
    .s_axil_araddr   (s_araddr),
    .s_axil_arprot   (s_arprot),
    .s_axil_arvalid  (s_arvalid),
    .s_axil_arready  (s_arready),
    .s_axil_rdata    (s_rdata),
    .s_axil_rresp    (s_rresp),
    .s_axil_rvalid   (s_rvalid),
    .s_axil_rready   (s_rready),
    .m0_axil_awaddr  (m0_awaddr),
    .m0_axil_awprot  (m0_awprot),
    .m0_axil_awvalid (m0_awvalid),
    .m0_axil_awready (m0_awready),
    .m0_axil_wdata   (m0_wdata),
    .m0_axil_wstrb   (m0_wstrb),
    .m0_axil_wvalid  (m0_wvalid),
    .m0_axil_wready  (m0_wready),
    .m0_axil_bresp   (m0_bresp),
    .m0_axil_bvalid  (m0_bvalid),
    .m0_axil_bready  (m0_bready),
    .m0_axil_araddr  (m0_araddr),
    .m0_axil_arprot  (m0_arprot),
    .m0_axil_arvalid (m0_arvalid),
    .m0_axil_arready (m0_arready),
    .m0_axil_rdata   (m0_rdata),
    .m0_axil_rresp   (m0_rresp),
    .m0_axil_rvalid  (m0_rvalid),
    .m0_axil_rready  (m0_rready),
    .m1_axil_awaddr  (m1_awaddr),
    .m1_axil_awprot  (m1_awprot),
    .m1_axil_awvalid (m1_awvalid),
    .m1_axil_awready (m1_awready),
    .m1_axil_wdata   (m1_wdata),
    .m1_axil_wstrb   (m1_wstrb),
    .m1_axil_wvalid  (m1_wvalid),
    .m1_axil_wready  (m1_wready),
    .m1_axil_bresp   (m1_bresp),
    .m1_axil_bvalid  (m1_bvalid),
    .m1_axil_bready  (m1_bready),
    .m1_axil_araddr  (m1_araddr),
    .m1_axil_arprot  (m1_arprot),
    .m1_axil_arvalid (m1_arvalid),
    .m1_axil_arready (m1_arready),
    .m1_axil_rdata   (m1_rdata),
    .m1_axil_rresp   (m1_rresp),
    .m1_axil_rvalid  (m1_rvalid),
    .m1_axil_rready  (m1_rready)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---- reset ----
    step(); step();
    chk("reset_all_valid_ready", 64'(all_vr), 64'h0);
    chk("reset_bresp", 64'(s_bresp), 64'h0);
    chk("reset_rdata", 64'(s_rdata), 64'h0);
    rst = 1'b1;
    step();
    chk("post_reset_readies", 64'({s_awready, s_wready, s_arready}), 64'h7);

    // ---- write m0, AW three cycles before W ----
    s_awaddr = 32'h4060_0004; s_awprot = 3'd2; s_awvalid = 1'b1;
    step();
    s_awvalid = 1'b0;
    chk("t1_aw_captured", 64'({s_awready, s_wready, m0_awvalid}), 64'b010);
    step(); step();
    s_wdata = 32'h41; s_wstrb = 4'h1; s_wvalid = 1'b1;
    step();
    s_wvalid = 1'b0;
    chk("t1_m0_valids", 64'({m0_awvalid, m0_wvalid, m1_awvalid, m1_wvalid}), 64'b1100);
    chk("t1_m0_awaddr", 64'(m0_awaddr), 64'h4060_0004);
    chk("t1_m0_awprot", 64'(m0_awprot), 64'h2);
    chk("t1_m0_wdata", 64'(m0_wdata), 64'h41);
    chk("t1_m0_wstrb", 64'(m0_wstrb), 64'h1);
    m0_awready = 1'b1; m0_wready = 1'b1;
    step();
    m0_awready = 1'b0; m0_wready = 1'b0;
    chk("t1_fwd_done", 64'({m0_awvalid, m0_wvalid, m0_bready, s_bvalid}), 64'b0010);
    m0_bvalid = 1'b1; m0_bresp = 2'b00;
    step();
    m0_bvalid = 1'b0;
    chk("t1_bvalid", 64'({s_bvalid, m0_bready, m1_bready}), 64'b100);
    chk("t1_bresp", 64'(s_bresp), 64'h0);
    s_bready = 1'b1;
    step();
    s_bready = 1'b0;
    chk("t1_b_done_awready", 64'({s_bvalid, s_awready, s_wready}), 64'b011);

    // ---- read m1 ----
    s_araddr = 32'h3800_BFF8; s_arvalid = 1'b1;
    step();
    s_arvalid = 1'b0;
    chk("t2_m1_arvalid", 64'({s_arready, m1_arvalid, m0_arvalid}), 64'b010);
    chk("t2_m1_araddr", 64'(m1_araddr), 64'h3800_BFF8);
    m1_arready = 1'b1;
    step();
    m1_arready = 1'b0;
    chk("t2_m1_rready", 64'({m1_arvalid, m1_rready, m0_rready}), 64'b010);
    m1_rvalid = 1'b1; m1_rdata = 32'h1234_5678; m1_rresp = 2'b00;
    step();
    m1_rvalid = 1'b0;
    chk("t2_rvalid", 64'({s_rvalid, m1_rready}), 64'b10);
    chk("t2_rdata", 64'(s_rdata), 64'h1234_5678);
    chk("t2_rresp", 64'(s_rresp), 64'h0);
    s_rready = 1'b1;
    step();
    s_rready = 1'b0;
    chk("t2_r_done", 64'({s_rvalid, s_arready}), 64'b01);

    // ---- read miss ----
    s_araddr = 32'h8000_0000; s_arvalid = 1'b1;
    step();
    s_arvalid = 1'b0;
    chk("t3_miss_rvalid", 64'({s_rvalid, m0_arvalid, m1_arvalid}), 64'b100);
    chk("t3_miss_rdata", 64'(s_rdata), 64'h0);
    chk("t3_miss_rresp", 64'(s_rresp), 64'h3);
    s_rready = 1'b1;
    step();
    s_rready = 1'b0;
    chk("t3_miss_done", 64'({s_rvalid, s_arready}), 64'b01);

    // ---- write miss just past the m0 window ----
    s_awaddr = 32'h4060_1000; s_awvalid = 1'b1;
    s_wdata = 32'h5; s_wstrb = 4'hF; s_wvalid = 1'b1;
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("t4_wmiss_bvalid", 64'({s_bvalid, m0_awvalid, m1_awvalid}), 64'b100);
    chk("t4_wmiss_bresp", 64'(s_bresp), 64'h3);
    s_bready = 1'b1;
    step();
    s_bready = 1'b0;
    chk("t4_wmiss_done", 64'({s_bvalid, s_awready}), 64'b01);

    // ---- concurrent m0 write and m1 read, upstream readies held low ----
    s_awaddr = 32'h4060_0010; s_awvalid = 1'b1;
    s_wdata = 32'h0000_AA55; s_wstrb = 4'hF; s_wvalid = 1'b1;
    s_araddr = 32'h3800_0020; s_arvalid = 1'b1;
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    chk("t5_fwd_both", 64'({m0_awvalid, m0_wvalid, m1_arvalid, m1_awvalid, m0_arvalid}),
        64'b11100);
    m0_awready = 1'b1; m0_wready = 1'b1; m1_arready = 1'b1;
    step();
    m0_awready = 1'b0; m0_wready = 1'b0; m1_arready = 1'b0;
    chk("t5_resp_readies", 64'({m0_bready, m1_rready}), 64'b11);
    m0_bvalid = 1'b1; m0_bresp = 2'b10;
    m1_rvalid = 1'b1; m1_rdata = 32'hCAFE_0001; m1_rresp = 2'b01;
    step();
    m0_bvalid = 1'b0; m1_rvalid = 1'b0;
    chk("t5_both_valid", 64'({s_bvalid, s_rvalid}), 64'b11);
    s_awaddr = 32'h4060_0020; s_awvalid = 1'b1;
    s_araddr = 32'h3800_0040; s_arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_hold_valids", 64'({s_bvalid, s_rvalid}), 64'b11);
      chk("t5_hold_bresp", 64'(s_bresp), 64'h2);
      chk("t5_hold_rdata", 64'({s_rresp, s_rdata}), {30'h0, 2'b01, 32'hCAFE_0001});
      chk("t5_no_accept", 64'({s_awready, s_arready, m0_awvalid, m1_arvalid}), 64'h0);
    end
    s_awvalid = 1'b0; s_arvalid = 1'b0;
    s_bready = 1'b1; s_rready = 1'b1;
    step();
    s_bready = 1'b0; s_rready = 1'b0;
    chk("t5_both_done", 64'({s_bvalid, s_rvalid, s_awready, s_arready}), 64'b0011);

    // ---- reset while forwarding ----
    s_awaddr = 32'h4060_0008; s_awvalid = 1'b1;
    s_wdata = 32'h77; s_wstrb = 4'h3; s_wvalid = 1'b1;
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("t6_in_fwd", 64'(m0_awvalid), 64'h1);
    rst = 1'b0;
    step();
    chk("t6_reset_all_zero", 64'(all_vr), 64'h0);
    rst = 1'b1;
    step();
    chk("t6_idle_after_reset", 64'({s_awready, s_wready, s_arready, m0_awvalid}), 64'b1110);

    // ---- m0 awready delayed four cycles, wready immediate ----
    s_awaddr = 32'h4060_0FFC; s_awvalid = 1'b1;
    s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hC; s_wvalid = 1'b1;
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("t7_fwd", 64'({m0_awvalid, m0_wvalid}), 64'b11);
    m0_wready = 1'b1;
    step();
    m0_wready = 1'b0;
    chk("t7_w_first", 64'({m0_awvalid, m0_wvalid, m0_bready}), 64'b100);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t7_aw_stable", 64'({m0_awvalid, m0_awaddr}), {31'h0, 1'b1, 32'h4060_0FFC});
    end
    m0_awready = 1'b1;
    step();
    m0_awready = 1'b0;
    chk("t7_aw_done", 64'({m0_awvalid, m0_bready}), 64'b01);
    m0_bvalid = 1'b1; m0_bresp = 2'b00;
    step();
    m0_bvalid = 1'b0;
    chk("t7_bvalid", 64'({s_bvalid, s_bresp}), 64'b100);
    step();
    chk("t7_b_held", 64'({s_bvalid, m0_bready}), 64'b10);
    s_bready = 1'b1;
    step();
    chk("t7_b_done", 64'(s_bvalid), 64'h0);
    step();
    s_bready = 1'b0;
    chk("t7_single_b", 64'(s_bvalid), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
